reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/rst_seq_pkg.sv | 18 +
 rtl/rst_sync.sv | 25 ++
 rtl/reset_sequencer.sv | 134 +++++++++++++
 tb/tb_reset_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// State encoding and counter sizing live here.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    QUIET   = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam int LOSS_W = 8;

  function automatic int cnt_w(input int max_v);
    return $clog2(max_v) + 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Multi-flop synchronizer with a selectable reset value.
// Reset loads every stage with RST_VAL.
module rst_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  assign ff_d = {ff_q[STAGES-2:0], d_i};
  assign q_o  = ff_q[STAGES-1];

  // shift the async input through the chain
  always_ff @(posedge clk_i) begin
    if (rst_i) ff_q <= {STAGES{RST_VAL}};
    else       ff_q <= ff_d;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Debounced, staggered reset release for NUM_CH domains.
// Any request slams every domain back into reset at once.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int STEP_CYC     = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              CLK_LOCKED,
  input  logic              BOARD_RST_SW,
  input  logic              SL_RST_N,
  output logic [NUM_CH-1:0] RST_N,
  output logic              RST_DONE,
  output logic [7:0]        LOSS_CNT
);

  localparam int QW = cnt_w(DEBOUNCE_CYC);
  localparam int SW = cnt_w(STEP_CYC);
  localparam logic [QW-1:0] DEB_C = QW'(DEBOUNCE_CYC);
  localparam logic [SW-1:0] STP_C = SW'(STEP_CYC);

  logic locked_s, sw_s, slrst_s, req;

  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock (
    .clk_i(SYS_CLK), .rst_i(SYS_RST),
    .d_i(CLK_LOCKED), .q_o(locked_s)
  );

  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sw (
    .clk_i(SYS_CLK), .rst_i(SYS_RST),
    .d_i(BOARD_RST_SW), .q_o(sw_s)
  );

  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sl (
    .clk_i(SYS_CLK), .rst_i(SYS_RST),
    .d_i(SL_RST_N), .q_o(slrst_s)
  );

  assign req = ~locked_s | sw_s | ~slrst_s;

  state_e              state_q, state_d;
  logic [QW-1:0]       qcnt_q, qcnt_d, qinc;
  logic [SW-1:0]       scnt_q, scnt_d, sinc;
  logic [NUM_CH-1:0]   rst_n_q, rst_n_d, rst_nxt;
  logic                done_q, done_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;

  assign qinc    = qcnt_q + QW'(1);
  assign sinc    = scnt_q + SW'(1);
  assign rst_nxt = (rst_n_q << 1) | NUM_CH'(1);

  // state, counters and registered outputs
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q <= HOLD;
      qcnt_q  <= '0;
      scnt_q  <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      scnt_q  <= scnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  // next-state, release staggering and loss counting
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    scnt_d  = scnt_q;
    rst_n_d = rst_n_q;
    loss_d  = loss_q;
    unique case (state_q)
      HOLD: begin
        rst_n_d = '0;
        qcnt_d  = '0;
        scnt_d  = '0;
        if (!req) state_d = QUIET;
      end
      QUIET: begin
        if (req) begin
          state_d = HOLD;
          qcnt_d  = '0;
        end else if (qinc == DEB_C) begin
          state_d = RELEASE;
          qcnt_d  = '0;
          scnt_d  = '0;
          rst_n_d = NUM_CH'(1);
        end else begin
          qcnt_d = qinc;
        end
      end
      RELEASE: begin
        if (req) begin
          state_d = HOLD;
          rst_n_d = '0;
          scnt_d  = '0;
        end else if (&rst_n_q) begin
          // single-channel build: bit 0 was the last one
          state_d = RUN;
        end else if (sinc == STP_C) begin
          rst_n_d = rst_nxt;
          scnt_d  = '0;
          if (&rst_nxt) state_d = RUN;
        end else begin
          scnt_d = sinc;
        end
      end
      RUN: begin
        if (req) begin
          state_d = HOLD;
          rst_n_d = '0;
          if (loss_q != '1) loss_d = loss_q + LOSS_W'(1);
        end
      end
      default: state_d = HOLD;
    endcase
    done_d = (state_d == RUN);
  end

  assign RST_N    = rst_n_q;
  assign RST_DONE = done_q;
  assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer.
// NUM_CH=3, DEBOUNCE_CYC=8, STEP_CYC=4, SYNC_STAGES=2.
module tb_reset_sequencer;
  import rst_seq_pkg::*;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       locked, sw, sl_n;
  logic [2:0] rst_n;
  logic       done;
  logic [7:0] loss;

  int n_vec  = 0;
  int n_miss = 0;

  reset_sequencer #(
    .NUM_CH(3), .DEBOUNCE_CYC(8),
    .STEP_CYC(4), .SYNC_STAGES(2)
  ) dut (
    .SYS_CLK(clk), .SYS_RST(sys_rst),
    .CLK_LOCKED(locked), .BOARD_RST_SW(sw),
    .SL_RST_N(sl_n), .RST_N(rst_n),
    .RST_DONE(done), .LOSS_CNT(loss)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    locked  = 1'b1;
    sw      = 1'b0;
    sl_n    = 1'b1;
    tick(3);
    chk("rst_rstn", 32'(rst_n), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_loss", 32'(loss), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(HOLD));

    // clean power-up
    sys_rst = 1'b0;
    tick(10);
    chk("pu_c10", 32'(rst_n), 32'h0);
    tick(1);
    chk("pu_c11", 32'(rst_n), 32'h1);
    chk("pu_c11_done", 32'(done), 32'h0);
    tick(3);
    chk("pu_c14", 32'(rst_n), 32'h1);
    tick(1);
    chk("pu_c15", 32'(rst_n), 32'h3);
    tick(3);
    chk("pu_c18", 32'(rst_n), 32'h3);
    chk("pu_c18_done", 32'(done), 32'h0);
    tick(1);
    chk("pu_c19", 32'(rst_n), 32'h7);
    chk("pu_c19_done", 32'(done), 32'h1);
    tick(2);

    // one-cycle lock loss while running
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    chk("ll_pre", 32'(rst_n), 32'h7);
    tick(1);
    chk("ll_rstn", 32'(rst_n), 32'h0);
    chk("ll_done", 32'(done), 32'h0);
    chk("ll_loss", 32'(loss), 32'h1);
    tick(8);
    chk("ll_rs8", 32'(rst_n), 32'h0);
    tick(1);
    chk("ll_rs9", 32'(rst_n), 32'h1);
    tick(4);
    chk("ll_rs13", 32'(rst_n), 32'h3);

    // SYS_RST in the middle of release
    sys_rst = 1'b1;
    tick(1);
    chk("mr_rstn", 32'(rst_n), 32'h0);
    chk("mr_state", 32'(dut.state_q), 32'(HOLD));
    chk("mr_loss", 32'(loss), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    tick(2);

    // release interrupted by the USB bridge reset
    sys_rst = 1'b0;
    tick(11);
    chk("ir_c11", 32'(rst_n), 32'h1);
    sl_n = 1'b0;
    tick(2);
    chk("ir_c13", 32'(rst_n), 32'h1);
    tick(1);
    chk("ir_c14", 32'(rst_n), 32'h0);
    chk("ir_loss", 32'(loss), 32'h0);
    sl_n = 1'b1;
    tick(10);
    chk("ir_c24", 32'(rst_n), 32'h0);
    tick(1);
    chk("ir_c25", 32'(rst_n), 32'h1);

    // push-button bounce during debounce
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    tick(8);
    sw = 1'b1;
    tick(1);
    sw = 1'b0;
    tick(2);
    chk("bn_c11", 32'(rst_n), 32'h0);
    tick(8);
    chk("bn_c19", 32'(rst_n), 32'h0);
    tick(1);
    chk("bn_c20", 32'(rst_n), 32'h1);
    chk("bn_loss", 32'(loss), 32'h0);
    tick(10);
    chk("bn_run", 32'(rst_n), 32'h7);
    chk("bn_done", 32'(done), 32'h1);

    // repeated run-state losses saturate the counter
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(19);
      if (i == 0)   chk("sat_1", 32'(loss), 32'd1);
      if (i == 253) chk("sat_254", 32'(loss), 32'd254);
      if (i == 254) chk("sat_255", 32'(loss), 32'd255);
    end
    chk("sat_end", 32'(loss), 32'd255);
    chk("sat_rstn", 32'(rst_n), 32'h7);
    chk("sat_done", 32'(done), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
